// File: rtl/mod_compose.sv
// Shift-and-add compose engine: rebuilds a dividend as result = q*b + r.
// Fixed 32-iteration RUN phase with a 64-bit accumulator; start/done handshake.
module mod_compose (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] q,
    input  logic [31:0] b,
    input  logic [31:0] r,
    output logic [31:0] result,
    output logic        overflow,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mq_q, mq_d;
    logic [63:0] mb_q, mb_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        done_q, done_d;
    logic [63:0] acc_step_s;
    logic        capture_s;

    // Next-state, datapath step and completion capture
    always_comb begin
        state_d    = state_q;
        mq_d       = mq_q;
        mb_d       = mb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        capture_s  = 1'b0;
        acc_step_s = mq_q[0] ? (acc_q + mb_q) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_step_s;
                mb_d  = {mb_q[62:0], 1'b0};
                mq_d  = {1'b0, mq_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d    = S_DONE;
                    result_d   = acc_step_s[31:0];
                    overflow_d = |acc_step_s[63:32];
                    done_d     = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    capture_s = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Operand load shared by IDLE and DONE; the counter always restarts at 0
        if (capture_s) begin
            state_d = S_RUN;
            mq_d    = q;
            mb_d    = {32'd0, b};
            acc_d   = {32'd0, r};
            cnt_d   = 5'd0;
        end else begin
            mq_d = mq_d;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mq_q       <= 32'd0;
            mb_q       <= 64'd0;
            acc_q      <= 64'd0;
            cnt_q      <= 5'd0;
            result_q   <= 32'd0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mq_q       <= mq_d;
            mb_q       <= mb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule
